// File: rtl/signed_product_restore.sv
// Output stage of the signed multiplier: turns an unsigned magnitude plus a sign
// into a two's-complement product, negating one CHUNK-wide slice per cycle.
module signed_product_restore #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag,
  input  logic             neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [CHUNK:0]   chunk_sum_s;

  // A negative result only overflows when the magnitude exceeds 2^(WIDTH-1).
  function automatic logic calc_ovf(input logic [WIDTH-1:0] m, input logic n);
    logic o;
    if (n) begin
      o = m[WIDTH-1] & (|m[WIDTH-2:0]);
    end else begin
      o = m[WIDTH-1];
    end
    return o;
  endfunction

  // Next-state, chunked negation datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    chunk_sum_s = {1'b0, ~result_q[idx_q*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          result_d = mag;
          ovf_d    = calc_ovf(mag, neg);
          idx_d    = '0;
          carry_d  = 1'b1;
          if (neg) begin
            state_d = CONV;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        carry_d = chunk_sum_s[CHUNK];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b1;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_signed_product_restore.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor pops and
// compares them whenever the block presents a result.
module tb_signed_product_restore;

  localparam int W = 64;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] mag = '0;
  logic         neg = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pcnt     = 0;
  int   last_hs  = -100;
  bit   seen     = 1'b0;
  bit   hs_prev  = 1'b0;

  signed_product_restore dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .neg(neg), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled just after the falling edge, when all drivers have settled
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      seen    = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) check("valid_one_cycle", {63'd0, out_valid}, 64'd0);
      hs_prev = 1'b0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = sb[0];
          if (!seen) begin
            check("latency", 64'(pcnt - e.acc), 64'(e.lat));
            seen = 1'b1;
          end
          check("result", result, e.res);
          check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          check("in_ready_done", {63'd0, in_ready}, 64'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen    = 1'b0;
            hs_prev = 1'b1;
            last_hs = pcnt;
          end
        end
      end else if (seen) begin
        check("valid_dropped", {63'd0, out_valid}, 64'd1);
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [W-1:0] m, input logic n, input logic [W-1:0] er,
                      input logic eo, input bit chk_b2b);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    mag      = m;
    neg      = n;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      check("accept_timeout", 64'(t), 64'd0);
    end else begin
      if (chk_b2b) check("b2b_accept_cycle", 64'(pcnt), 64'(last_hs + 1));
      e.res = er;
      e.ovf = eo;
      e.acc = pcnt;
      e.lat = n ? N + 1 : 1;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] m;
    logic         n;

    @(negedge clk);
    check("rst_result", result, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;

    // Back-to-back with in_valid held high throughout
    send(64'h0000_0000_0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
    send(64'h0000_0000_0001_0000, 1'b1, 64'hFFFF_FFFF_FFFF_0000, 1'b0, 1'b1);
    send(64'h0000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(64'h8000_0000_0000_0001, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send(64'h8000_0000_0000_0005, 1'b0, 64'h8000_0000_0000_0005, 1'b1, 1'b1);
    drop_valid();
    drain();

    // Result held while downstream stalls for three cycles
    out_ready = 1'b0;
    send(64'h0000_0000_1234_5678, 1'b0, 64'h0000_0000_1234_5678, 1'b0, 1'b0);
    drop_valid();
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    drain();

    for (int i = 0; i < 8; i++) begin
      m        = {$urandom(), $urandom()};
      m[63:62] = 2'b00;
      n        = 1'($urandom_range(1, 0));
      send(m, n, n ? (64'd0 - m) : m, 1'b0, 1'b0);
    end
    drop_valid();
    drain();

    // Asynchronous reset in the middle of a conversion
    send(64'h0000_0000_0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0);
    drop_valid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check("arst_result", result, 64'd0);
    check("arst_ovf", {63'd0, ovf}, 64'd0);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_product_restore.md
Name: signed_product_restore

Overview:
- Output stage of the signed multiplier datapath.
- Takes the unsigned magnitude product from the unsigned Vedic core plus the result sign (sign_a XOR sign_b).
- Returns the signed two's-complement product.
- Negation runs as a chunked ripple over several cycles so that no 64-bit carry chain sits on one path. Input and output use valid/ready handshakes.

Parameters:
- WIDTH, 64, product width in bits.
- CHUNK, 16, bits negated per cycle. WIDTH must be an integer multiple of CHUNK.
- N (derived, not overridable), WIDTH/CHUNK, number of conversion cycles.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  mag/neg valid.
- in_ready  output  1  block can accept an operand.
- mag  input  WIDTH  unsigned magnitude product.
- neg  input  1  1 = result is negative.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  signed two's-complement product.
- ovf  output  1  magnitude is not representable in WIDTH signed bits.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state = IDLE; result = 0; ovf = 0; out_valid = 0; busy = 0; in_ready = 1.
  - Internal chunk index = 0; carry = 1; captured mag/neg = 0.
  - Reset mid-conversion or with a result pending abandons that result. Nothing is emitted after reset release until a new accept.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept happens when in_valid && in_ready at a rising edge. On accept:
    - Capture mag and neg.
    - Compute ovf = neg ? (mag[WIDTH-1] && |mag[WIDTH-2:0]) : mag[WIDTH-1].
    - If neg = 0: result <= mag, go to DONE.
    - If neg = 1: result <= mag, index <= 0, carry <= 1, go to CONV.
- CONV:
  - in_ready = 0.
  - Each cycle: {carry, result[index*CHUNK +: CHUNK]} <= ~result[index*CHUNK +: CHUNK] + carry, then index increments.
  - On the cycle that processes index N-1, go to DONE. The final carry-out is discarded.
- DONE:
  - out_valid = 1, in_ready = 0.
  - result and ovf are held stable until out_ready = 1 at a rising edge; then go to IDLE.
  - out_valid does not drop without a handshake.
- Latency, counted from the accept cycle to the first out_valid cycle:
  - 1 cycle for neg = 0.
  - N+1 cycles for neg = 1 (5 with defaults).
- Throughput: one operation in flight. No new accept until the DONE handshake completes and the block is back in IDLE.
- Boundary conditions:
  - neg = 1, mag = 0: result = 0, ovf = 0. The carry propagates through every chunk.
  - neg = 1, mag = 2^(WIDTH-1): result = 0x8000_0000_0000_0000, ovf = 0.
  - neg = 0, mag[WIDTH-1] = 1: result = mag unchanged, ovf = 1.
  - out_ready held high in DONE: out_valid is high for exactly one cycle.
  - in_valid held high in CONV/DONE: ignored. The operand is accepted only once the block is back in IDLE.

Test Plan:
- Reset asserted asynchronously mid-CONV (mag = 0x6, neg = 1) -> all outputs immediately 0, in_ready = 1. After release, no out_valid appears without a new accept.
- mag = 0x0000_0000_0000_0006, neg = 1, out_ready = 1 -> result = 0xFFFF_FFFF_FFFF_FFFA, ovf = 0, out_valid exactly 5 cycles after accept, for 1 cycle.
- mag = 0x0000_0000_0001_0000, neg = 1 (exercises carry across chunk boundaries) -> result = 0xFFFF_FFFF_FFFF_0000.
- mag = 0x0000_0000_1234_5678, neg = 0 -> result = 0x0000_0000_1234_5678 one cycle after accept. With out_ready held low for 3 cycles, result and out_valid stay stable and in_ready stays 0.
- mag = 0, neg = 1 -> result = 0, ovf = 0.
- mag = 0x8000_0000_0000_0000, neg = 1 -> result = 0x8000_0000_0000_0000, ovf = 0.
- mag = 0x8000_0000_0000_0001, neg = 1 -> ovf = 1.
- Back-to-back operands with in_valid held high -> second operand accepted only in the cycle after the first DONE handshake.
- Random mag < 2^62 with random neg vs. a reference model -> results match.
